// File: rtl/fpu_bus_host.sv
// fpu_bus_host: CPU-side bus master for the FPU register interface.
// Takes an operand pair and an opcode over a valid/ready handshake. It writes
// them byte-wise to FPU registers 0..8 and waits for cmd_end. It then reads
// result registers 9..C, pulses end_ack and returns the result on a response
// handshake.
// Ports:
//   clk, arst_n                           clock, async active-low reset
//   req_valid/ready, req_a/b/op           request handshake and payload
//   rsp_valid/ready, rsp_result/timeout   response handshake and payload
//   fpu_addr, fpu_data_out/oe/in          FPU register address and data bus
//   fpu_cs, fpu_rd, fpu_wr                active-low bus strobes
//   fpu_cmd_end, fpu_busy, fpu_end_ack    FPU command status / acknowledge
module fpu_bus_host #(
    parameter int unsigned STROBE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic [3:0]  fpu_addr,
    output logic [7:0]  fpu_data_out,
    output logic        fpu_data_oe,
    input  logic [7:0]  fpu_data_in,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy,
    output logic        fpu_end_ack
);

    localparam logic [3:0]  STROBE_LAST  = 4'(STROBE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StWaitEnd, StAck, StResp
    } state_t;

    state_t      r_state;
    logic [31:0] r_a, r_b, r_result;
    logic [3:0]  r_op, r_index, r_strobe_cnt, r_addr;
    logic [15:0] r_timeout_cnt;
    logic [7:0]  r_data_out;
    logic        r_data_oe, r_cs, r_rd, r_wr, r_end_ack, r_rsp_valid, r_rsp_timeout;

    logic        w_is_write;
    logic [3:0]  w_next_index;
    logic [7:0]  w_next_data;
    logic [1:0]  w_rd_byte;

    // Gated by arst_n so the host never advertises readiness while held in reset.
    assign req_ready    = arst_n && (r_state == StIdle) && !fpu_busy && !fpu_cmd_end;
    assign w_is_write   = (r_index <= 4'd8);
    assign w_next_index = r_index + 4'd1;
    assign w_rd_byte    = 2'(r_index - 4'd9);

    // Write data for the access that follows the current one.
    always_comb begin
        w_next_data = 8'h00;
        case (w_next_index)
            4'd1:    w_next_data = r_a[15:8];
            4'd2:    w_next_data = r_a[23:16];
            4'd3:    w_next_data = r_a[31:24];
            4'd4:    w_next_data = r_b[7:0];
            4'd5:    w_next_data = r_b[15:8];
            4'd6:    w_next_data = r_b[23:16];
            4'd7:    w_next_data = r_b[31:24];
            4'd8:    w_next_data = {4'b0000, r_op};
            default: w_next_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= StIdle;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_result      <= '0;
            r_index       <= '0;
            r_strobe_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_addr        <= '0;
            r_data_out    <= '0;
            r_data_oe     <= 1'b0;
            r_cs          <= 1'b1;
            r_rd          <= 1'b1;
            r_wr          <= 1'b1;
            r_end_ack     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        r_a           <= req_a;
                        r_b           <= req_b;
                        r_op          <= req_op;
                        r_index       <= 4'd0;
                        r_addr        <= 4'd0;
                        r_data_out    <= req_a[7:0];
                        r_data_oe     <= 1'b1;
                        r_result      <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= StSetup;
                    end
                end
                StSetup: begin
                    r_cs         <= 1'b0;
                    r_wr         <= !w_is_write;
                    r_rd         <= w_is_write;
                    r_strobe_cnt <= 4'd0;
                    r_state      <= StStrobe;
                end
                StStrobe: begin
                    if (r_strobe_cnt == STROBE_LAST) begin
                        r_cs <= 1'b1;
                        r_rd <= 1'b1;
                        r_wr <= 1'b1;
                        // Read data is taken on the edge that ends the strobe.
                        if (!w_is_write) begin
                            unique case (w_rd_byte)
                                2'd0: r_result[7:0]   <= fpu_data_in;
                                2'd1: r_result[15:8]  <= fpu_data_in;
                                2'd2: r_result[23:16] <= fpu_data_in;
                                2'd3: r_result[31:24] <= fpu_data_in;
                            endcase
                        end
                        r_state <= StHold;
                    end else begin
                        r_strobe_cnt <= r_strobe_cnt + 4'd1;
                    end
                end
                StHold: begin
                    if (r_index == 4'd8) begin
                        r_data_oe     <= 1'b0;
                        r_timeout_cnt <= '0;
                        r_state       <= StWaitEnd;
                    end else if (r_index == 4'd12) begin
                        r_end_ack <= 1'b1;
                        r_state   <= StAck;
                    end else begin
                        r_index    <= w_next_index;
                        r_addr     <= w_next_index;
                        r_data_out <= w_next_data;
                        r_data_oe  <= (w_next_index <= 4'd8);
                        r_state    <= StSetup;
                    end
                end
                StWaitEnd: begin
                    if (fpu_cmd_end) begin
                        r_index    <= 4'd9;
                        r_addr     <= 4'd9;
                        r_data_out <= 8'h00;
                        r_state    <= StSetup;
                    end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                        r_rsp_timeout <= 1'b1;
                        r_result      <= '0;
                        r_end_ack     <= 1'b1;
                        r_state       <= StAck;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
                    end
                end
                StAck: begin
                    if (!fpu_cmd_end) begin
                        r_end_ack   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_result;
    assign rsp_timeout  = r_rsp_timeout;
    assign fpu_addr     = r_addr;
    assign fpu_data_out = r_data_out;
    assign fpu_data_oe  = r_data_oe;
    assign fpu_cs       = r_cs;
    assign fpu_rd       = r_rd;
    assign fpu_wr       = r_wr;
    assign fpu_end_ack  = r_end_ack;

endmodule

// File: tb/tb_fpu_bus_host.sv
// tb_fpu_bus_host: directed bench for fpu_bus_host. Instance 0 runs with
// STROBE_CYCLES=1 and TIMEOUT_CYCLES=16. Instance 1 runs with STROBE_CYCLES=3.
// Each instance has an FPU bus model that logs writes and serves read bytes
// only in the last strobe cycle. It raises cmd_end two cycles after the
// opcode write and drops it on end_ack. It also counts bus protocol faults.
module tb_fpu_bus_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        req_valid [2];
    logic        rsp_ready [2];
    logic [31:0] req_a, req_b;
    logic [3:0]  req_op;
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_timeout [2];
    logic [31:0] rsp_result [2];
    logic [3:0]  fpu_addr [2];
    logic [7:0]  fpu_data_out [2];
    logic        fpu_data_oe [2];
    logic        fpu_cs [2];
    logic        fpu_rd [2];
    logic        fpu_wr [2];
    logic        fpu_end_ack [2];
    logic        tb_busy, stale_end, no_end, clr;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] rom(input logic [3:0] a);
        case (a)
            4'd11:   rom = 8'h70;
            4'd12:   rom = 8'h40;
            default: rom = 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_m
        localparam int S = (g == 0) ? 1 : 3;
        logic [7:0]  din = 8'hEE;
        logic        m_end = 1'b0;
        logic        cmd_end_w;
        int          lo_cnt = 0, since_start = 0, wr_cnt = 0, rd_cnt = 0;
        int          viol = 0, end_dly = 0, ack_pulses = 0;
        logic        prev_ack = 1'b0, w_lat = 1'b0;
        logic [3:0]  a_lat = 4'd0;
        logic [7:0]  d_lat = 8'd0;
        logic [7:0]  wlog [16];
        logic [71:0] wpack;

        assign cmd_end_w = m_end | stale_end;
        assign wpack = {wlog[8], wlog[7], wlog[6], wlog[5], wlog[4],
                        wlog[3], wlog[2], wlog[1], wlog[0]};

        fpu_bus_host #(
            .STROBE_CYCLES (S),
            .TIMEOUT_CYCLES((g == 0) ? 16 : 1024)
        ) u_dut (
            .clk          (clk),
            .arst_n       (arst_n),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_a        (req_a),
            .req_b        (req_b),
            .req_op       (req_op),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_result   (rsp_result[g]),
            .rsp_timeout  (rsp_timeout[g]),
            .fpu_addr     (fpu_addr[g]),
            .fpu_data_out (fpu_data_out[g]),
            .fpu_data_oe  (fpu_data_oe[g]),
            .fpu_data_in  (din),
            .fpu_cs       (fpu_cs[g]),
            .fpu_rd       (fpu_rd[g]),
            .fpu_wr       (fpu_wr[g]),
            .fpu_cmd_end  (cmd_end_w),
            .fpu_busy     (tb_busy),
            .fpu_end_ack  (fpu_end_ack[g])
        );

        always @(negedge clk) begin
            if (!arst_n) begin
                lo_cnt = 0; m_end = 1'b0; end_dly = 0; din = 8'hEE; prev_ack = 1'b0;
            end else begin
                if (clr) begin
                    wr_cnt = 0; rd_cnt = 0; ack_pulses = 0;
                    for (int i = 0; i < 16; i++) wlog[i] = 8'h55;
                end
                if (end_dly > 0) begin
                    end_dly--;
                    if (end_dly == 0 && !(g == 0 && no_end)) m_end = 1'b1;
                end
                if (fpu_end_ack[g]) m_end = 1'b0;
                if (fpu_end_ack[g] && !prev_ack) ack_pulses++;
                prev_ack = fpu_end_ack[g];
                if (!fpu_rd[g] && !fpu_wr[g]) viol++;
                if ((!fpu_rd[g] || !fpu_wr[g]) && fpu_cs[g]) viol++;
                if (!fpu_cs[g]) begin
                    if (lo_cnt == 0) begin
                        // Back-to-back accesses must start exactly S+2 cycles apart.
                        if (fpu_addr[g] != 4'd0 && fpu_addr[g] != 4'd9 && since_start != S + 2)
                            viol++;
                        since_start = 0;
                        a_lat = fpu_addr[g];
                        d_lat = fpu_data_out[g];
                        w_lat = !fpu_wr[g];
                    end else if (fpu_addr[g] != a_lat || (w_lat && fpu_data_out[g] != d_lat)) begin
                        viol++;
                    end
                    if (fpu_data_oe[g] != w_lat) viol++;
                    lo_cnt++;
                    din = (!w_lat && lo_cnt == S) ? rom(a_lat) : 8'hEE;
                end else begin
                    if (lo_cnt != 0) begin
                        if (lo_cnt != S || fpu_addr[g] != a_lat) viol++;
                        if (w_lat) begin
                            if (fpu_data_out[g] != d_lat || !fpu_data_oe[g]) viol++;
                            wlog[a_lat] = d_lat;
                            wr_cnt++;
                            if (a_lat == 4'd8) end_dly = 2;
                        end else begin
                            rd_cnt++;
                        end
                        lo_cnt = 0;
                    end
                    din = 8'hEE;
                end
                since_start++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    // Issue one request on instance idx; returns with the accept edge just past.
    task automatic issue(input int idx);
        @(posedge clk);
        #1 req_valid[idx] = 1'b1;
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            #1 n++;
            if (rsp_valid[idx]) break;
        end
        check_eq("rsp_arrived", 96'(rsp_valid[idx]), 96'(1));
    endtask

    task automatic release_rsp(input int idx);
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[idx] = 1'b0;
        check_eq("rsp_release", 96'({rsp_valid[idx], req_ready[idx]}), 96'(2'b01));
    endtask

    int   n;
    logic cs_seen, found;

    initial begin
        arst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end
        req_a = 32'h3FC00000; req_b = 32'h40100000; req_op = 4'h0;
        tb_busy = 1'b0; stale_end = 1'b0; no_end = 1'b0; clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_ctl", 96'({fpu_cs[i], fpu_rd[i], fpu_wr[i], fpu_data_oe[i],
                     fpu_end_ack[i], rsp_valid[i], rsp_timeout[i], req_ready[i]}), 96'(8'b1110_0000));
            check_eq("reset_data", 96'({fpu_addr[i], fpu_data_out[i], rsp_result[i]}), 96'(0));
        end
        arst_n = 1'b1;

        // Stale FPU status must block acceptance.
        cs_seen = 1'b0;
        tb_busy = 1'b1;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1 if (!fpu_cs[0] || !fpu_cs[1]) cs_seen = 1'b1;
        end
        check_eq("stale_busy_ready", 96'({req_ready[0], req_ready[1]}), 96'(0));
        tb_busy = 1'b0; stale_end = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 if (!fpu_cs[0] || !fpu_cs[1]) cs_seen = 1'b1;
        end
        check_eq("stale_end_ready", 96'({req_ready[0], req_ready[1]}), 96'(0));
        check_eq("stale_no_bus", 96'(cs_seen), 96'(0));
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        stale_end = 1'b0;
        #1 check_eq("idle_ready", 96'({req_ready[0], req_ready[1]}), 96'(2'b11));

        // Add on both instances at once.
        do_clear();
        @(posedge clk);
        #1 req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        wait_rsp(0, 300, n);
        check_eq("add_s1_latency", 96'(n), 96'(42));
        check_eq("add_s1_result", 96'({rsp_timeout[0], rsp_result[0]}), 96'({1'b0, 32'h40700000}));
        check_eq("add_s1_writes", 96'(g_m[0].wpack), 96'(72'h00_40_10_00_00_3F_C0_00_00));
        check_eq("add_s1_counts", 96'(g_m[0].wr_cnt * 100 + g_m[0].rd_cnt * 10 + g_m[0].ack_pulses),
                 96'(941));
        // Backpressure: response held, no new request accepted.
        repeat (10) begin
            @(posedge clk);
            #1 check_eq("bp_hold", 96'({rsp_valid[0], req_ready[0], rsp_result[0]}),
                        96'({1'b1, 1'b0, 32'h40700000}));
        end
        release_rsp(0);

        wait_rsp(1, 400, n);
        check_eq("add_s3_result", 96'({rsp_timeout[1], rsp_result[1]}), 96'({1'b0, 32'h40700000}));
        check_eq("add_s3_writes", 96'(g_m[1].wpack), 96'(72'h00_40_10_00_00_3F_C0_00_00));
        check_eq("add_s3_counts", 96'(g_m[1].wr_cnt * 100 + g_m[1].rd_cnt * 10 + g_m[1].ack_pulses),
                 96'(941));
        release_rsp(1);

        // Timeout on instance 0: cmd_end never arrives.
        no_end = 1'b1;
        req_op = 4'h3;
        do_clear();
        issue(0);
        wait_rsp(0, 200, n);
        check_eq("to_result", 96'({rsp_timeout[0], rsp_result[0]}), 96'({1'b1, 32'h0}));
        check_eq("to_counts", 96'(g_m[0].wr_cnt * 100 + g_m[0].rd_cnt * 10 + g_m[0].ack_pulses),
                 96'(901));
        check_eq("to_op_byte", 96'(g_m[0].wlog[8]), 96'(8'h03));
        check_eq("to_latency_window", 96'(n >= 40 && n <= 46), 96'(1));
        release_rsp(0);
        no_end = 1'b0;
        req_op = 4'h0;

        // Reset in the middle of the index-10 read on instance 1.
        do_clear();
        issue(1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1 if (fpu_addr[1] == 4'd10 && !fpu_rd[1]) found = 1'b1;
        end
        check_eq("reach_idx10_strobe", 96'(found), 96'(1));
        #2 arst_n = 1'b0;
        #1 check_eq("async_reset_bus", 96'({fpu_cs[1], fpu_rd[1], fpu_wr[1], fpu_end_ack[1],
                    rsp_valid[1]}), 96'(5'b11100));
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        do_clear();
        issue(1);
        wait_rsp(1, 400, n);
        check_eq("post_reset_result", 96'({rsp_timeout[1], rsp_result[1]}),
                 96'({1'b0, 32'h40700000}));
        check_eq("post_reset_counts", 96'(g_m[1].wr_cnt * 100 + g_m[1].rd_cnt * 10 + g_m[1].ack_pulses),
                 96'(941));
        release_rsp(1);

        check_eq("bus_protocol_s1", 96'(g_m[0].viol), 96'(0));
        check_eq("bus_protocol_s3", 96'(g_m[1].viol), 96'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
